// File: rtl/rvfi_pkg.sv
// Shared RVFI retire-record definitions: field offsets, record width and typedef.
package rvfi_pkg;

    localparam int OFF_INSN      = 0;
    localparam int OFF_RS1_ADDR  = OFF_INSN + 32;
    localparam int OFF_RS2_ADDR  = OFF_RS1_ADDR + 5;
    localparam int OFF_RD_ADDR   = OFF_RS2_ADDR + 5;
    localparam int OFF_RS1_RDATA = OFF_RD_ADDR + 5;
    localparam int OFF_RS2_RDATA = OFF_RS1_RDATA + 32;
    localparam int OFF_RD_WDATA  = OFF_RS2_RDATA + 32;
    localparam int OFF_PC_RDATA  = OFF_RD_WDATA + 32;
    localparam int OFF_PC_WDATA  = OFF_PC_RDATA + 32;
    localparam int OFF_MEM_ADDR  = OFF_PC_WDATA + 32;
    localparam int OFF_MEM_WMASK = OFF_MEM_ADDR + 32;
    localparam int OFF_MEM_RDATA = OFF_MEM_WMASK + 4;
    localparam int OFF_MEM_WDATA = OFF_MEM_RDATA + 32;
    localparam int REC_W         = OFF_MEM_WDATA + 32;

    localparam int ORDER_W = 64;

    // Declared MSB-first so that insn lands at bit 0, matching the offsets above.
    typedef struct packed {
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_addr;
        logic [31:0] pc_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rs1_rdata;
        logic [4:0]  rd_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rs1_addr;
        logic [31:0] insn;
    } rvfi_rec_t;

endpackage

// File: rtl/rvfi_fifo.sv
// Multi-write, single-read circular buffer. Up to NRET pre-packed entries are
// written per cycle starting at the write pointer; one entry is read per cycle.
module rvfi_fifo #(
    parameter  int NRET  = 2,
    parameter  int DEPTH = 16,
    parameter  int W     = 371,
    localparam int CW    = $clog2(NRET + 1),
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CW-1:0]       wr_cnt,
    input  logic [NRET*W-1:0]   wr_data,
    input  logic                rd_en,
    output logic [W-1:0]        rd_data,
    output logic [LW-1:0]       level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write: the first wr_cnt packed entries go to consecutive slots.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NRET; i++) begin
            if (i < int'(wr_cnt)) begin
                mem[wr_ptr + AW'(i)] <= wr_data[i*W +: W];
            end
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_cnt);
            rd_ptr <= rd_ptr + AW'(rd_en);
            level  <= level + LW'(wr_cnt) - LW'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI trace buffer: packs valid retire channels into a FIFO, tags each record
// with a running 64-bit order, and counts whole groups dropped when full.
module rvfi_trace_buffer
    import rvfi_pkg::*;
#(
    parameter  int NRET  = 2,
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NRET-1:0]        in_valid,
    input  logic [NRET*REC_W-1:0]  in_rec,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REC_W-1:0]       out_rec,
    output logic [ORDER_W-1:0]     out_order,
    output logic [15:0]            drop_count,
    output logic [LW-1:0]          level
);

    localparam int CW = $clog2(NRET + 1);
    localparam int EW = REC_W + ORDER_W;

    logic [ORDER_W-1:0] order_cnt;
    logic [CW-1:0]      n_valid;
    logic [NRET*EW-1:0] packed_data;
    logic [CW-1:0]      wr_cnt;
    logic [EW-1:0]      head;
    logic [16:0]        drop_sum;
    logic               accept;

    // Acceptance looks only at registered occupancy so a whole group always fits.
    assign in_ready  = reset | (level <= LW'(DEPTH - NRET));
    assign accept    = in_ready & ~reset;
    assign out_valid = ~reset & (level != '0);
    assign wr_cnt    = accept ? n_valid : '0;
    assign drop_sum  = {1'b0, drop_count} + 17'(n_valid);

    // Compact valid channels in ascending order and stamp consecutive order values.
    always_comb begin
        n_valid     = '0;
        packed_data = '0;
        for (int i = 0; i < NRET; i++) begin
            if (in_valid[i]) begin
                packed_data[n_valid*EW +: EW] = {order_cnt + ORDER_W'(n_valid),
                                                 in_rec[i*REC_W +: REC_W]};
                n_valid = n_valid + CW'(1);
            end
        end
    end

    // Order advances only for accepted records; drops saturate at 0xFFFF.
    always_ff @(posedge clock) begin
        if (reset) begin
            order_cnt  <= '0;
            drop_count <= '0;
        end else if (accept) begin
            order_cnt <= order_cnt + ORDER_W'(n_valid);
        end else if (n_valid != '0) begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    rvfi_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_cnt  (wr_cnt),
        .wr_data (packed_data),
        .rd_en   (out_valid & out_ready),
        .rd_data (head),
        .level   (level)
    );

    assign out_rec   = head[REC_W-1:0];
    assign out_order = head[EW-1:REC_W];

endmodule

// File: doc/rvfi_trace_buffer.md
RVFI_TRACE_BUFFER -- requirements
Module: rvfi_trace_buffer

Interface
REQ-001 SHALL have parameter NRET, default 2, meaning retire channels per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, meaning record-FIFO entries (power of two, 4..256, DEPTH >= NRET).
REQ-003 SHALL have ports `clock` and `reset` only as clock and reset; one clock, reset synchronous and active-high.
REQ-004 `clock`  in  1  sole clock; all state updates on rising edge.
REQ-005 `reset`  in  1  synchronous active-high reset.
REQ-006 `in_valid`  in  NRET  per-channel retire strobe; bit i qualifies record i.
REQ-007 `in_rec`  in  NRET*REC_W  packed retire records; channel i at bits [i*REC_W +: REC_W].
REQ-008 `in_ready`  out  1  buffer can accept a full NRET group this cycle.
REQ-009 `out_valid`  out  1  `out_rec`/`out_order` hold a record.
REQ-010 `out_ready`  in  1  consumer accepts the record.
REQ-011 `out_rec`  out  REC_W  head record, same field layout as `in_rec`.
REQ-012 `out_order`  out  64  rvfi_order of head record.
REQ-013 `drop_count`  out  16  saturating count of dropped records.
REQ-014 `level`  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL drive `in_ready` = 1 iff (DEPTH - level) >= NRET, from registered occupancy only.
REQ-016 SHALL, when `in_ready`=1, enqueue every channel with `in_valid` set in ascending channel index, packing with no gaps.
REQ-017 SHALL, when `in_ready`=0 and any `in_valid` bit set, drop all valid records of that cycle and add their count to `drop_count`, saturating at 0xFFFF.
REQ-018 SHALL assign each enqueued record `out_order` equal to a 64-bit counter, then advance it by the number enqueued; dropped records consume no order values; counter wraps modulo 2^64.
REQ-019 SHALL complete an output transfer when `out_valid` and `out_ready` are both 1; at most one record per cycle.
REQ-020 SHALL hold `out_rec`/`out_order` stable while `out_valid`=1 and `out_ready`=0.
REQ-021 SHALL present a record enqueued in cycle N no earlier than cycle N+1 (no combinational in-to-out bypass).
REQ-022 SHALL, on simultaneous enqueue and dequeue, update `level` by (enqueued - 1).
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL deassert `out_valid` only when `level` = 0.

Reset
REQ-025 SHALL, while `reset`=1, clear `level`, pointers, order counter and `drop_count` to 0 and drive `out_valid`=0 and `in_ready`=1.
REQ-026 SHALL discard all buffered records when reset asserts mid-operation; records presented during reset are neither enqueued nor counted as drops.
REQ-027 SHALL not require FIFO storage contents to be reset; `out_rec` is don't-care while `out_valid`=0.

Structure
REQ-028 SHALL take REC_W (307), field offsets (insn, rs1/rs2/rd addr, rs1/rs2 rdata, rd_wdata, pc_rdata, pc_wdata, mem_addr, mem_wmask, mem_rdata, mem_wdata) and the record typedef from shared package rvfi_pkg.
REQ-029 SHALL instantiate one sub-module, rvfi_fifo (multi-write, single-read circular buffer, parameters NRET, DEPTH, width REC_W+64).
REQ-030 SHALL keep the packing, drop and order logic in rvfi_trace_buffer.

Verification
REQ-031 SHALL cover: NRET=2, DEPTH=16, in_valid=2'b11 one cycle, out_ready=1 -> two records on consecutive cycles starting next cycle, out_order 0 then 1.
REQ-032 SHALL cover: in_valid=2'b10 -> channel 1 record stored in next slot, out_order continues without gap.
REQ-033 SHALL cover: out_ready=0, in_valid=2'b11 for 8 cycles -> level=16, in_ready=0; 9th cycle group dropped, drop_count=2, level stays 16.
REQ-034 SHALL cover: level=15, in_valid=2'b01 with out_ready=1 -> in_ready=0, record dropped, level=14, drop_count+1.
REQ-035 SHALL cover: reset asserted with level=10 -> next cycle level=0, out_valid=0, drop_count=0, next accepted record out_order=0.
REQ-036 SHALL cover: drop_count preloaded to 0xFFFE via sustained overflow, 2 further drops -> drop_count=0xFFFF and stays there.
